prog_clk_divider: RTL and testbench

//  Runtime-programmable integer clock divider; successor to the fixed /2,/4,/10 dividers.

---
 rtl/prog_div_pkg.sv | 18 +
 rtl/prog_clk_divider_if.sv | 32 +++
 rtl/prog_div_core.sv | 85 ++++++++
 rtl/prog_clk_divider.sv | 84 ++++++++
 tb/tb_prog_clk_divider.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_MIN    smallest legal divisor; smaller loads are clamped up to it
//   DIV_W_DEF  default divisor/counter width
//   div_t      divisor type at the default width
//   high_len   number of posedge-registered high cycles per period for divisor N
package prog_div_pkg;

  localparam int DIV_MIN   = 2;
  localparam int DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // N/2 for even N and (N-1)/2 for odd N are both a right shift by one.
  function automatic logic [31:0] high_len(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control and output bundle of prog_clk_divider.
//   en        run enable; low holds clk_div/tick low
//   div_i     requested divisor
//   div_load  one-cycle strobe capturing div_i as the pending divisor
//   div_ack   one-cycle pulse after the pending divisor became active
//   div_err   sticky flag: last load was below the minimum and got clamped
//   clk_div   divided clock
//   tick      one-cycle pulse at the start of every clk_div period
// master: the controlling block; slave: the divider.
interface prog_clk_divider_if #(
  parameter int DIV_W = 8
);

  logic             en;
  logic [DIV_W-1:0] div_i;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             clk_div;
  logic             tick;

  modport master (
    output en, div_i, div_load,
    input  div_ack, div_err, clk_div, tick
  );

  modport slave (
    input  en, div_i, div_load,
    output div_ack, div_err, clk_div, tick
  );

endinterface

// File: rtl/prog_div_core.sv
// Period counter and output phase generation.
//   clk, rst   source clock, synchronous active-high reset
//   en         run request; low idles the counter and forces outputs low
//   n_act      divisor governing the current period
//   boundary   high when the coming edge starts a new period (wrap or idle)
//   clk_div    divided clock
//   tick       one-cycle pulse in the first cycle of each period
// Build option ODD_DUTY50_EN adds a negedge stage that stretches the high
// phase by half a clk cycle for odd divisors, giving 50% duty.
module prog_div_core
  import prog_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] n_act,
  output logic             boundary,
  output logic             clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] h;
  logic             run_q, run_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    h        = DIV_W'(high_len(32'(n_act)));
    // Equality compare keeps N = 2**DIV_W-1 safe from counter overflow.
    wrap     = run_q && (cnt_q == (n_act - DIV_W'(1)));
    // An idle counter starts a fresh period at the very next edge.
    boundary = !run_q || wrap;
    run_d    = en;
    cnt_d    = '0;
    if (en && !boundary) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    // Outputs are registered from the next counter value so they line up
    // with the cycle in which cnt holds that value.
    tick_d = en && (cnt_d == '0);
    pos_d  = en && (cnt_d < h);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef ODD_DUTY50_EN
  logic neg_q, neg_d;

  // Half-cycle delayed copy of the high phase, only for odd divisors.
  always_comb begin
    neg_d = pos_q & n_act[0];
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign clk_div = pos_q | neg_q;
`else
  assign clk_div = pos_q;
`endif

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider, N in [2, 2**DIV_W-1].
//   clk, rst   source clock, synchronous active-high reset
//   bus        prog_clk_divider_if slave: en, div_i, div_load in;
//              div_ack, div_err, clk_div, tick out
// Parameters: DIV_W (divisor/counter width), DEFAULT_DIV (divisor after reset).
// Build option ODD_DUTY50_EN: 50% duty for odd divisors via a negedge stage.
// A loaded divisor is held pending and only becomes active on a period
// boundary (or the next edge when idle), so clk_div never glitches.
module prog_clk_divider
  import prog_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input logic                 clk,
  input logic                 rst,
  prog_clk_divider_if.slave   bus
);

  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] load_val;
  logic [DIV_W-1:0] pend_eff;
  logic             pend_vld_eff;
  logic             load_low;
  logic             apply;
  logic             boundary;

  always_comb begin
    load_low     = bus.div_i < DIV_W'(DIV_MIN);
    load_val     = load_low ? DIV_W'(DIV_MIN) : bus.div_i;
    // A load in the wrap cycle is applied at that same wrap, and a newer
    // load simply overwrites an older pending one.
    pend_eff     = bus.div_load ? load_val : pend_q;
    pend_vld_eff = bus.div_load || pend_vld_q;
    apply        = pend_vld_eff && boundary;
    n_d          = apply ? pend_eff : n_q;
    pend_d       = pend_eff;
    pend_vld_d   = pend_vld_eff && !apply;
    ack_d        = apply;
    err_d        = err_q;
    if (bus.div_load) begin
      err_d = load_low;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= DIV_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      n_q        <= n_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // The core still sees the old divisor on the apply edge; the new period
  // starts at cnt=0 which is high for any legal divisor, and n_q is
  // updated in time for the comparisons of the following cycles.
  prog_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .n_act    (n_q),
    .boundary (boundary),
    .clk_div  (bus.clk_div),
    .tick     (bus.tick)
  );

  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
module tb_prog_clk_divider;

  localparam int DIV_W = 8;
  localparam int DEF   = 10;
`ifdef ODD_DUTY50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  prog_clk_divider_if #(.DIV_W(DIV_W)) bus ();

  prog_clk_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks the edge index at which the current period
  // started; period position is the distance from that edge.
  int m_edge  = 0;
  int m_start = 0;
  bit m_run   = 0;
  int m_n     = DEF;
  bit m_pvld  = 0;
  int m_pend  = 0;
  bit m_ack   = 0;
  bit m_err   = 0;
  bit m_tick  = 0;
  bit m_pos   = 0;
  bit m_ppos  = 0;
  bit m_podd  = 0;

  function automatic int exp_hi(input int n);
    return n / 2 + ((ODD50 && (n % 2 == 1)) ? 1 : 0);
  endfunction

  task automatic model_edge();
    int  age;
    bit  bnd;
    int  di;
    m_edge++;
    if (rst) begin
      m_run = 0; m_n = DEF; m_pvld = 0; m_ack = 0; m_err = 0;
      m_tick = 0; m_pos = 0; m_ppos = 0; m_podd = 0;
      return;
    end
    m_ppos = m_pos;
    m_podd = (m_n % 2 == 1);
    age = (m_edge - 1) - m_start;
    bnd = !m_run || (age == m_n - 1);
    if (bus.div_load) begin
      di     = int'(bus.div_i);
      m_pend = (di < 2) ? 2 : di;
      m_pvld = 1;
      m_err  = (di < 2);
    end
    m_ack = 0;
    if (m_pvld && bnd) begin
      m_n    = m_pend;
      m_pvld = 0;
      m_ack  = 1;
    end
    if (!bus.en) begin
      m_run = 0;
    end else begin
      if (bnd) m_start = m_edge;
      m_run = 1;
    end
    age    = m_edge - m_start;
    m_tick = m_run && (age == 0);
    m_pos  = m_run && (age < m_n / 2);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_tick", bus.tick, m_tick);
    chk("model_clk_div", bus.clk_div, m_pos | (ODD50 & m_ppos & m_podd));
    chk("model_div_ack", bus.div_ack, m_ack);
    chk("model_div_err", bus.div_err, m_err);
  endtask

  // Starts in a tick cycle; runs until the next tick. Optional loads at
  // loop indices a1/a2. hi and acks include the starting cycle.
  task automatic run_period(input int a1, input int v1, input int a2, input int v2,
                            output int per, output int hi, output int acks);
    per  = 0;
    hi   = int'(bus.clk_div);
    acks = int'(bus.div_ack);
    for (int i = 0; i < 600; i++) begin
      bus.div_load = (i == a1) || (i == a2);
      bus.div_i    = DIV_W'((i == a2) ? v2 : v1);
      step();
      per++;
      bus.div_load = 1'b0;
      if (bus.tick === 1'b1) return;
      hi   += int'(bus.clk_div);
      acks += int'(bus.div_ack);
    end
    checks++;
    errs++;
    $display("FAIL period_timeout: got no tick expected tick within 600 cycles");
  endtask

  typedef struct {
    bit rst; bit en; bit ld; int dv;
    bit t; bit c; bit c50; bit a; bit e;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int per, hi, acks, r;

    rst = 1'b1;
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_i = '0;

    //            rst en ld dv  t  c c50 a  e
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{0, 1, 0, 0, 1, 1, 1, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0, 1, 1, 1, 0, 1};
    tbl[5]  = '{0, 1, 1, 5, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 0, 1, 1, 1, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

    #2;
    for (int i = 0; i < 13; i++) begin
      rst          = tbl[i].rst;
      bus.en       = tbl[i].en;
      bus.div_load = tbl[i].ld;
      bus.div_i    = DIV_W'(tbl[i].dv);
      step();
      chk($sformatf("tbl%0d_tick", i), bus.tick, tbl[i].t);
      chk($sformatf("tbl%0d_clk_div", i), bus.clk_div, ODD50 ? tbl[i].c50 : tbl[i].c);
      chk($sformatf("tbl%0d_ack", i), bus.div_ack, tbl[i].a);
      chk($sformatf("tbl%0d_err", i), bus.div_err, tbl[i].e);
    end
    bus.div_load = 1'b0;

    // Default divisor after reset.
    rst = 1'b1; bus.en = 1'b0;
    step();
    chk("rst_clk_div", bus.clk_div, 0);
    chk("rst_ack", bus.div_ack, 0);
    rst = 1'b0; bus.en = 1'b1;
    step();
    chk("first_tick", bus.tick, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("def_per", per, 10); chk("def_hi", hi, 5); chk("def_acks", acks, 0);

    // Mid-period load of 7: current period completes at 10.
    run_period(3, 7, -1, 0, per, hi, acks);
    chk("ld7_cur_per", per, 10); chk("ld7_cur_hi", hi, 5); chk("ld7_cur_acks", acks, 0);
    chk("ld7_ack_at_wrap", bus.div_ack, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n7_per", per, 7); chk("n7_hi", hi, exp_hi(7)); chk("n7_acks", acks, 1);

    // Load 4 then 6 before the boundary: only 6 is applied.
    run_period(1, 4, 3, 6, per, hi, acks);
    chk("ld46_cur_per", per, 7); chk("ld46_cur_acks", acks, 0);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n6_per", per, 6); chk("n6_hi", hi, 3); chk("n6_acks", acks, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n6b_per", per, 6); chk("n6b_acks", acks, 0);

    // Load 0: clamped to 2 with error, then load 5 clears it.
    run_period(2, 0, -1, 0, per, hi, acks);
    chk("ld0_cur_per", per, 6);
    chk("ld0_err", bus.div_err, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n2_per", per, 2); chk("n2_hi", hi, 1); chk("n2_acks", acks, 1);
    run_period(0, 5, -1, 0, per, hi, acks);
    chk("ld5_cur_per", per, 2);
    chk("ld5_err_clr", bus.div_err, 0);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n5_per", per, 5); chk("n5_hi", hi, exp_hi(5)); chk("n5_acks", acks, 1);

    // Drop en mid-period, load while idle, then re-enable.
    step(); step();
    bus.en = 1'b0;
    step(); step();
    chk("idle_clk_div", bus.clk_div, 0);
    chk("idle_tick", bus.tick, 0);
    bus.div_load = 1'b1; bus.div_i = DIV_W'(9);
    step();
    bus.div_load = 1'b0;
    chk("idle_ack", bus.div_ack, 1);
    bus.en = 1'b1;
    step();
    chk("en_tick", bus.tick, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n9_per", per, 9); chk("n9_hi", hi, exp_hi(9)); chk("n9_acks", acks, 0);

    // Reset with a load pending.
    step(); step();
    bus.div_load = 1'b1; bus.div_i = DIV_W'(3);
    step();
    bus.div_load = 1'b0;
    rst = 1'b1;
    step();
    chk("rstpend_tick", bus.tick, 0);
    chk("rstpend_clk_div", bus.clk_div, 0);
    chk("rstpend_ack", bus.div_ack, 0);
    rst = 1'b0;
    step();
    chk("rstpend_tick2", bus.tick, 1);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("rstpend_per", per, 10); chk("rstpend_acks", acks, 0);

    // Largest divisor.
    run_period(0, 255, -1, 0, per, hi, acks);
    chk("ld255_cur_per", per, 10);
    run_period(-1, 0, -1, 0, per, hi, acks);
    chk("n255_per", per, 255); chk("n255_hi", hi, exp_hi(255)); chk("n255_acks", acks, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.div_load = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 9));
      if (r == 0)      bus.div_i = DIV_W'($urandom_range(0, 1));
      else if (r == 1) bus.div_i = DIV_W'(255);
      else if (r == 2) bus.div_i = DIV_W'(254);
      else             bus.div_i = DIV_W'($urandom_range(2, 12));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
